// File: rtl/ipsl_pcie_dma_mwr_data_buf_if.sv
// MWr payload buffer bus: user write side, TX-controller read side.
// master drives the i_* requests; slave (the buffer) drives the o_* status/data.
interface ipsl_pcie_dma_mwr_data_buf_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  i_wr_en;
    logic [127:0]          i_wr_data;
    logic                  o_wr_full;
    logic [ADDR_WIDTH:0]   o_buf_level;
    logic                  i_buf_clr;
    logic                  i_rd_en;
    logic [9:0]            i_rd_length;
    logic                  i_mwr_tlp_tx;
    logic                  i_mwr_tx_hold;
    logic                  o_gen_tlp_start;
    logic [127:0]          o_rd_data;
    logic                  o_last_data;
    logic                  o_busy;

    modport master (
        output i_wr_en, i_wr_data, i_buf_clr,
        output i_rd_en, i_rd_length, i_mwr_tlp_tx, i_mwr_tx_hold,
        input  o_wr_full, o_buf_level, o_gen_tlp_start,
        input  o_rd_data, o_last_data, o_busy
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_buf_clr,
        input  i_rd_en, i_rd_length, i_mwr_tlp_tx, i_mwr_tx_hold,
        output o_wr_full, o_buf_level, o_gen_tlp_start,
        output o_rd_data, o_last_data, o_busy
    );
endinterface

// File: rtl/ipsl_pcie_dma_mwr_data_buf.sv
// DMA MWr payload buffer: 128-bit circular buffer plus TLP beat sequencer.
// Ports: clk, rst_n (async low), bus (slave): write side, level/full, payload req/stream.
module ipsl_pcie_dma_mwr_data_buf #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic clk,
    input  logic rst_n,
    ipsl_pcie_dma_mwr_data_buf_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        SEND,
        WAIT_RELEASE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [127:0]          r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic [8:0]            r_beat_cnt;

    logic       w_full;
    logic       w_wr_acc;
    logic       w_cons;
    logic       w_data_rdy;
    logic [8:0] w_beats;

    assign w_full   = (r_level == FULL_LVL);
    assign w_wr_acc = bus.i_wr_en && !w_full && !bus.i_buf_clr;
    assign w_cons   = (r_state == SEND) && bus.i_mwr_tlp_tx &&
                      !bus.i_mwr_tx_hold;

    // Length 0 encodes 1024 DW, i.e. 256 beats.
    assign w_beats = (bus.i_rd_length == 10'd0) ? 9'd256 :
                     9'((11'(bus.i_rd_length) + 11'd3) >> 2);

    assign w_data_rdy = 32'(r_level) >= 32'(r_beat_cnt);

    // Payload RAM carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (bus.i_buf_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_cons)   r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_wr_acc, w_cons})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Length is captured only on leaving IDLE; upstream changes it mid-TLP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (bus.i_buf_clr) begin
            r_beat_cnt <= '0;
        end else if (r_state == IDLE && bus.i_rd_en) begin
            r_beat_cnt <= w_beats;
        end else if (w_cons) begin
            r_beat_cnt <= r_beat_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next              = r_state;
        bus.o_gen_tlp_start = 1'b0;
        bus.o_last_data     = 1'b0;
        bus.o_busy          = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (bus.i_rd_en) w_next = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (w_data_rdy) w_next = SEND;
            end
            SEND: begin
                bus.o_gen_tlp_start = 1'b1;
                bus.o_last_data     = (r_beat_cnt == 9'd1);
                if (w_cons && r_beat_cnt == 9'd1) w_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                // Hold until rd_en drops so one request never starts two TLPs.
                if (!bus.i_rd_en) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (bus.i_buf_clr) w_next = IDLE;
    end

    assign bus.o_wr_full   = w_full;
    assign bus.o_buf_level = r_level;
    assign bus.o_rd_data   = r_mem[r_rd_ptr];
endmodule

// File: tb/tb_ipsl_pcie_dma_mwr_data_buf.sv
// Bench for ipsl_pcie_dma_mwr_data_buf: queue-based payload model, per-cycle compare.
// Directed TLP scenarios plus randomized lengths, holds and concurrent writes.
module tb_ipsl_pcie_dma_mwr_data_buf;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ipsl_pcie_dma_mwr_data_buf_if #(.ADDR_WIDTH(AW)) bus ();

    ipsl_pcie_dma_mwr_data_buf #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: stored payload in arrival order, plus the request progress.
    logic [127:0] q[$];
    logic [127:0] hist[$];
    int m_ph  = 0;  // 0 none, 1 awaiting payload, 2 streaming, 3 awaiting rd_en drop
    int m_rem = 0;  // beats still to stream in the current TLP

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int n_beats(int len);
        return (len == 0) ? 256 : (len + 3) / 4;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_step();
        int lvl;
        bit cons;
        if (!rst_n || bus.i_buf_clr) begin
            q.delete();
            m_ph  = 0;
            m_rem = 0;
            return;
        end
        lvl  = q.size();
        cons = (m_ph == 2) && bus.i_mwr_tlp_tx && !bus.i_mwr_tx_hold;
        if (cons) void'(q.pop_front());
        if (bus.i_wr_en && lvl < DEPTH) q.push_back(bus.i_wr_data);
        case (m_ph)
            0: if (bus.i_rd_en) begin
                m_rem = n_beats(int'(bus.i_rd_length));
                m_ph  = 1;
            end
            1: if (lvl >= m_rem) m_ph = 2;
            2: if (cons) begin
                m_rem--;
                if (m_rem == 0) m_ph = 3;
            end
            3: if (!bus.i_rd_en) m_ph = 0;
            default: ;
        endcase
    endtask

    task automatic check_all();
        chk("level", 128'(bus.o_buf_level), 128'(q.size()));
        chk("full", 128'(bus.o_wr_full), 128'(q.size() == DEPTH));
        chk("start", 128'(bus.o_gen_tlp_start), 128'(m_ph == 2));
        chk("last", 128'(bus.o_last_data), 128'(m_ph == 2 && m_rem == 1));
        chk("busy", 128'(bus.o_busy), 128'(m_ph != 0));
        if (m_ph == 2 && q.size() > 0) chk("rd_data", bus.o_rd_data, q[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wr_beats(int n);
        for (int i = 0; i < n; i++) begin
            bus.i_wr_en   = 1'b1;
            bus.i_wr_data = rnd128();
            hist.push_back(bus.i_wr_data);
            tick();
        end
        bus.i_wr_en = 1'b0;
    endtask

    task automatic do_tlp(int len, int hold_pct, int tx_dly, bit rnd_wr);
        int cyc;
        bus.i_rd_en     = 1'b1;
        bus.i_rd_length = 10'(len);
        for (cyc = 0; cyc < 3000 && m_ph != 3; cyc++) begin
            bus.i_mwr_tlp_tx  = (cyc >= tx_dly);
            bus.i_mwr_tx_hold = ($urandom_range(99) < hold_pct);
            if (rnd_wr) begin
                bus.i_wr_en   = $urandom_range(1);
                bus.i_wr_data = rnd128();
            end
            tick();
        end
        bus.i_wr_en       = 1'b0;
        bus.i_mwr_tlp_tx  = 1'b0;
        bus.i_mwr_tx_hold = 1'b0;
        if (m_ph != 3) begin
            checks++;
            errors++;
            $display("FAIL tlp_timeout len %0d phase %0d", len, m_ph);
        end
        bus.i_rd_en = 1'b0;
        tick();
    endtask

    initial begin
        bus.i_wr_en       = 1'b0;
        bus.i_wr_data     = '0;
        bus.i_buf_clr     = 1'b0;
        bus.i_rd_en       = 1'b0;
        bus.i_rd_length   = '0;
        bus.i_mwr_tlp_tx  = 1'b0;
        bus.i_mwr_tx_hold = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start", 128'(bus.o_gen_tlp_start), 128'(0));
        chk("rst_busy", 128'(bus.o_busy), 128'(0));
        chk("rst_level", 128'(bus.o_buf_level), 128'(0));
        chk("rst_full", 128'(bus.o_wr_full), 128'(0));
        chk("rst_last", 128'(bus.o_last_data), 128'(0));
        #2 rst_n = 1'b1;
        tick();

        // 128 B TLP
        hist.delete();
        wr_beats(8);
        chk("t1_level8", 128'(bus.o_buf_level), 128'(8));
        bus.i_rd_en     = 1'b1;
        bus.i_rd_length = 10'd32;
        tick();
        chk("t1_start_c1", 128'(bus.o_gen_tlp_start), 128'(0));
        tick();
        chk("t1_start_c2", 128'(bus.o_gen_tlp_start), 128'(1));
        bus.i_mwr_tlp_tx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t1_beat", bus.o_rd_data, hist[i]);
            chk("t1_last", 128'(bus.o_last_data), 128'(i == 7));
            tick();
        end
        chk("t1_level0", 128'(bus.o_buf_level), 128'(0));
        chk("t1_release", 128'(bus.o_busy), 128'(1));
        tick();
        chk("t1_hold_rel", 128'(bus.o_busy), 128'(1));
        bus.i_rd_en      = 1'b0;
        bus.i_mwr_tlp_tx = 1'b0;
        tick();
        chk("t1_idle", 128'(bus.o_busy), 128'(0));

        // Partial final beat
        hist.delete();
        wr_beats(2);
        bus.i_rd_en     = 1'b1;
        bus.i_rd_length = 10'd5;
        tick();
        tick();
        bus.i_mwr_tlp_tx = 1'b1;
        chk("t2_b1", bus.o_rd_data, hist[0]);
        chk("t2_last1", 128'(bus.o_last_data), 128'(0));
        tick();
        chk("t2_b2", bus.o_rd_data, hist[1]);
        chk("t2_last2", 128'(bus.o_last_data), 128'(1));
        tick();
        chk("t2_level", 128'(bus.o_buf_level), 128'(0));
        bus.i_rd_en      = 1'b0;
        bus.i_mwr_tlp_tx = 1'b0;
        tick();

        // Late data
        hist.delete();
        wr_beats(2);
        bus.i_rd_en     = 1'b1;
        bus.i_rd_length = 10'd16;
        repeat (4) begin
            tick();
            chk("t3_wait", 128'(bus.o_gen_tlp_start), 128'(0));
        end
        wr_beats(1);
        chk("t3_wait3", 128'(bus.o_gen_tlp_start), 128'(0));
        wr_beats(1);
        chk("t3_wait4", 128'(bus.o_gen_tlp_start), 128'(0));
        chk("t3_level4", 128'(bus.o_buf_level), 128'(4));
        tick();
        chk("t3_send", 128'(bus.o_gen_tlp_start), 128'(1));
        bus.i_mwr_tlp_tx = 1'b1;
        repeat (4) tick();
        chk("t3_rel", 128'(bus.o_busy), 128'(1));
        bus.i_rd_en      = 1'b0;
        bus.i_mwr_tlp_tx = 1'b0;
        tick();

        // Hold mid-stream
        hist.delete();
        wr_beats(6);
        bus.i_rd_en     = 1'b1;
        bus.i_rd_length = 10'd24;
        tick();
        tick();
        bus.i_mwr_tlp_tx = 1'b1;
        tick();
        tick();
        bus.i_mwr_tx_hold = 1'b1;
        repeat (3) begin
            chk("t4_frozen", bus.o_rd_data, hist[2]);
            chk("t4_flevel", 128'(bus.o_buf_level), 128'(4));
            chk("t4_flast", 128'(bus.o_last_data), 128'(0));
            tick();
        end
        bus.i_mwr_tx_hold = 1'b0;
        for (int i = 2; i < 6; i++) begin
            chk("t4_beat", bus.o_rd_data, hist[i]);
            chk("t4_level", 128'(bus.o_buf_level), 128'(6 - i));
            chk("t4_last", 128'(bus.o_last_data), 128'(i == 5));
            tick();
        end
        chk("t4_end", 128'(bus.o_buf_level), 128'(0));
        bus.i_rd_en      = 1'b0;
        bus.i_mwr_tlp_tx = 1'b0;
        tick();

        // Full, dropped write, write+consume with pointer wrap
        hist.delete();
        wr_beats(512);
        chk("t5_full", 128'(bus.o_wr_full), 128'(1));
        chk("t5_lvl512", 128'(bus.o_buf_level), 128'(512));
        wr_beats(1);
        chk("t5_drop", 128'(bus.o_buf_level), 128'(512));
        for (int k = 0; k < 2; k++) begin
            bus.i_rd_en     = 1'b1;
            bus.i_rd_length = 10'd0;
            tick();
            tick();
            chk("t5_start", 128'(bus.o_gen_tlp_start), 128'(1));
            bus.i_mwr_tlp_tx = 1'b1;
            bus.i_wr_en      = 1'b1;
            repeat (256) begin
                bus.i_wr_data = rnd128();
                tick();
            end
            bus.i_wr_en = 1'b0;
            chk("t5_lvl511", 128'(bus.o_buf_level), 128'(511));
            bus.i_rd_en      = 1'b0;
            bus.i_mwr_tlp_tx = 1'b0;
            tick();
        end
        do_tlp(0, 20, 0, 1'b0);
        chk("t5_lvl255", 128'(bus.o_buf_level), 128'(255));
        bus.i_buf_clr = 1'b1;
        tick();
        bus.i_buf_clr = 1'b0;
        chk("t5_clr", 128'(bus.o_buf_level), 128'(0));

        // Back-to-back 32 DW TLPs
        hist.delete();
        wr_beats(16);
        do_tlp(32, 0, 0, 1'b0);
        do_tlp(32, 0, 0, 1'b0);
        chk("t6_b2b", 128'(bus.o_buf_level), 128'(0));

        // Flush while waiting for payload
        wr_beats(1);
        bus.i_rd_en     = 1'b1;
        bus.i_rd_length = 10'd32;
        tick();
        tick();
        chk("t6_wait", 128'(bus.o_busy), 128'(1));
        bus.i_buf_clr = 1'b1;
        bus.i_rd_en   = 1'b0;
        tick();
        bus.i_buf_clr = 1'b0;
        chk("t6_clr_idle", 128'(bus.o_busy), 128'(0));
        chk("t6_clr_lvl", 128'(bus.o_buf_level), 128'(0));

        // Randomized lengths, holds and concurrent writes
        repeat (8) begin
            do_tlp($urandom_range(1023), 30, $urandom_range(3), 1'b1);
        end
        bus.i_buf_clr = 1'b1;
        tick();
        bus.i_buf_clr = 1'b0;

        // Asynchronous reset mid-SEND
        wr_beats(4);
        bus.i_rd_en     = 1'b1;
        bus.i_rd_length = 10'd16;
        tick();
        tick();
        bus.i_mwr_tlp_tx = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_start", 128'(bus.o_gen_tlp_start), 128'(0));
        chk("ar_last", 128'(bus.o_last_data), 128'(0));
        chk("ar_busy", 128'(bus.o_busy), 128'(0));
        chk("ar_level", 128'(bus.o_buf_level), 128'(0));
        chk("ar_full", 128'(bus.o_wr_full), 128'(0));
        q.delete();
        m_ph  = 0;
        m_rem = 0;
        bus.i_rd_en      = 1'b0;
        bus.i_mwr_tlp_tx = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        wr_beats(2);
        do_tlp(8, 0, 0, 1'b0);
        chk("post_rst", 128'(bus.o_buf_level), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
